img_pingpong_buf: RTL and testbench
===================================

IMG_PINGPONG_BUF -- requirements
Module: img_pingpong_buf

Interface
REQ-001 SHALL have parameter ROW_W, default 512, bits per row (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 512, rows per frame bank.
REQ-003 SHALL have derived localparam AW = $clog2(DEPTH).
REQ-004 SHALL have port clk  in  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port we  in  1  row write request.
REQ-007 SHALL have port waddr  in  AW  write row index.
REQ-008 SHALL have port wdata  in  ROW_W  write row data.
REQ-009 SHALL have port wr_done  in  1  producer pulse: current write bank is complete.
REQ-010 SHALL have port wr_rdy  out  1  a bank is available for writing.
REQ-011 SHALL have port re  in  1  row read request.
REQ-012 SHALL have port raddr  in  AW  read row index.
REQ-013 SHALL have port rd_done  in  1  consumer pulse: current read bank is consumed.
REQ-014 SHALL have port rd_rdy  out  1  a full bank is available for reading.
REQ-015 SHALL have port rdata  out  ROW_W  registered read row.
REQ-016 SHALL have port rvalid  out  1  rdata holds data from an accepted read.
REQ-017 SHALL have port frm_cnt  out  16  count of frames completed by wr_done.

Function
REQ-018 SHALL hold two banks of DEPTH x ROW_W, with per-bank full flags, a write-bank pointer wsel and a read-bank pointer rsel.
REQ-019 SHALL drive wr_rdy = !full[wsel] and rd_rdy = full[rsel], combinationally from registers.
REQ-020 SHALL write wdata to bank wsel row waddr on an edge with we && wr_rdy; we && !wr_rdy is ignored.
REQ-021 SHALL, on wr_done && wr_rdy, set full[wsel], toggle wsel and increment frm_cnt mod 2^16; wr_done && !wr_rdy is ignored.
REQ-022 SHALL, on re && rd_rdy, register bank rsel row raddr into rdata one cycle later with rvalid=1.
REQ-023 SHALL hold rdata at its previous value and drive rvalid=0 in the cycle after any cycle without an accepted read.
REQ-024 SHALL, on rd_done && rd_rdy, clear full[rsel] and toggle rsel; rd_done && !rd_rdy is ignored.
REQ-025 SHALL, when re and rd_done are accepted on the same edge, return rdata from the bank being released.
REQ-026 SHALL, when wr_done and rd_done are accepted on the same edge, apply both updates, so that with both banks full wr_rdy rises the next cycle.
REQ-027 SHALL, when a write and wr_done are accepted on the same edge, store that row in the bank being completed.
REQ-028 SHALL treat waddr/raddr >= DEPTH (non-power-of-2 DEPTH) as no-ops for writes and as rdata = 0 with rvalid = 1 for reads.

Reset
REQ-029 SHALL, on rst, clear full[1:0], wsel, rsel, rvalid, rdata and frm_cnt to 0, giving wr_rdy=1 and rd_rdy=0 on the next cycle.
REQ-030 SHALL NOT reset memory contents; rst takes priority over all same-edge requests, including reset mid-frame.

Configuration
REQ-031 SHALL, with IMG_BUF_WBE_EN defined, add port wbe  in  ROW_W/8  byte enables, writing only enabled bytes of the row.
REQ-032 SHALL, without IMG_BUF_WBE_EN, have no wbe port and write whole rows.

Structure
REQ-033 SHALL take the ROW_W/DEPTH defaults and the frm_cnt width (16) from shared package img_buf_pkg.
REQ-034 SHALL place storage in sub-module img_bank_ram:
- simple dual-port, 2*DEPTH x ROW_W;
- address {bank, row};
- synchronous read, optional byte enables.
REQ-035 SHALL keep control flags, pointers and the counter in img_pingpong_buf.

Verification
REQ-036 SHALL check: reset, then write rows 0..3 = 0xA0..0xA3, wr_done -> wr_rdy=1, rd_rdy=1, frm_cnt=1; re raddr=2 -> next cycle rdata=0xA2, rvalid=1.
REQ-037 SHALL check: fill two frames without rd_done -> wr_rdy=0; a write of 0xFF to row 0 is dropped; rd_done -> wr_rdy=1 the next cycle; bank 0 row 0 reads the first-frame value.
REQ-038 SHALL check: both banks full, with wr_done and rd_done on the same edge -> rsel toggles, wr_done is ignored, frm_cnt is unchanged.
REQ-039 SHALL check: re with rd_rdy=0 -> rvalid=0 and rdata holds its last value.
REQ-040 SHALL check: rst asserted mid-frame with we=1 -> all outputs 0, wr_rdy=1, frm_cnt=0 the next cycle.
REQ-041 SHALL check: with IMG_BUF_WBE_EN, write 0 then write all-ones with wbe=...0001 -> the row reads 0x...00FF.

Source files
------------

// File: rtl/img_buf_pkg.sv
// img_buf_pkg -- shared defaults for the ping-pong image row buffer.
//   ROW_W_DEF  : default bits per row (multiple of 8)
//   DEPTH_DEF  : default rows per frame bank
//   FRM_CNT_W  : width of the completed-frame counter
package img_buf_pkg;

  localparam int ROW_W_DEF = 512;
  localparam int DEPTH_DEF = 512;
  localparam int FRM_CNT_W = 16;

endpackage

// File: rtl/img_bank_ram.sv
// img_bank_ram -- simple dual-port storage for both ping-pong banks.
// Holds 2*DEPTH rows of ROW_W bits, addressed as {bank, row}.
// Writes are synchronous. Reads are synchronous: rdata updates only on
// an enabled read and otherwise holds its value. Contents are never reset.
// Optional macro IMG_BUF_WBE_EN adds per-byte write enables (wbe).
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  {bank, row} write address
//   wdata  in  write row data
//   wbe    in  byte enables (IMG_BUF_WBE_EN only)
//   re     in  read enable
//   raddr  in  {bank, row} read address
//   rdata  out registered read row
module img_bank_ram
  import img_buf_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW:0]      waddr,
  input  logic [ROW_W-1:0] wdata,
`ifdef IMG_BUF_WBE_EN
  input  logic [ROW_W/8-1:0] wbe,
`endif
  input  logic             re,
  input  logic [AW:0]      raddr,
  output logic [ROW_W-1:0] rdata
);

  logic [ROW_W-1:0] mem_r [2][DEPTH];

  // Row write into the addressed bank (byte-masked when enables exist).
  always_ff @(posedge clk) begin
    if (we) begin
`ifdef IMG_BUF_WBE_EN
      for (int b = 0; b < ROW_W / 8; b++) begin
        if (wbe[b]) begin
          mem_r[waddr[AW]][waddr[AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
`else
      mem_r[waddr[AW]][waddr[AW-1:0]] <= wdata;
`endif
    end
  end

  // Synchronous read port; output holds when no read is enabled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr[AW]][raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/img_pingpong_buf.sv
// img_pingpong_buf -- two-bank ping-pong row buffer between an image
// producer and consumer. The producer fills bank wsel and closes it with
// wr_done; the consumer reads bank rsel and releases it with rd_done.
// Optional macro IMG_BUF_WBE_EN adds the wbe byte-enable port.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   we       in  row write request
//   waddr    in  write row index
//   wdata    in  write row data
//   wbe      in  byte enables (IMG_BUF_WBE_EN only)
//   wr_done  in  current write bank complete
//   wr_rdy   out a bank is free for writing
//   re       in  row read request
//   raddr    in  read row index
//   rd_done  in  current read bank consumed
//   rd_rdy   out a full bank is available for reading
//   rdata    out registered read row
//   rvalid   out rdata holds data from an accepted read
//   frm_cnt  out frames completed by wr_done (wraps)
module img_pingpong_buf
  import img_buf_pkg::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [ROW_W-1:0]     wdata,
`ifdef IMG_BUF_WBE_EN
  input  logic [ROW_W/8-1:0]   wbe,
`endif
  input  logic                 wr_done,
  output logic                 wr_rdy,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  input  logic                 rd_done,
  output logic                 rd_rdy,
  output logic [ROW_W-1:0]     rdata,
  output logic                 rvalid,
  output logic [FRM_CNT_W-1:0] frm_cnt
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [1:0]           full_r;
  logic                 wsel_r;
  logic                 rsel_r;
  logic                 rvalid_r;
  logic                 zero_r;
  logic [FRM_CNT_W-1:0] frm_cnt_r;

  logic                 waddr_ok_s;
  logic                 raddr_ok_s;
  logic                 wr_acc_s;
  logic                 wr_done_acc_s;
  logic                 rd_acc_s;
  logic                 rd_done_acc_s;
  logic                 ram_we_s;
  logic                 ram_re_s;
  logic [ROW_W-1:0]     ram_q_s;

  assign wr_rdy = ~full_r[wsel_r];
  assign rd_rdy = full_r[rsel_r];

  // Indices at or beyond DEPTH only occur for non-power-of-2 depths.
  assign waddr_ok_s    = ({1'b0, waddr} < DEPTH_W);
  assign raddr_ok_s    = ({1'b0, raddr} < DEPTH_W);
  assign wr_acc_s      = we & wr_rdy;
  assign wr_done_acc_s = wr_done & wr_rdy;
  assign rd_acc_s      = re & rd_rdy;
  assign rd_done_acc_s = rd_done & rd_rdy;

  // Reset overrides any same-edge request, so the RAM is gated too.
  assign ram_we_s = wr_acc_s & waddr_ok_s & ~rst;
  assign ram_re_s = rd_acc_s & raddr_ok_s & ~rst;

  // The RAM output register is not reset; zero_r forces rdata to 0 after
  // reset and after an out-of-range read, and holds with the RAM output.
  assign rdata   = zero_r ? {ROW_W{1'b0}} : ram_q_s;
  assign rvalid  = rvalid_r;
  assign frm_cnt = frm_cnt_r;

  // Bank flags, pointers, read-valid and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_r    <= 2'b00;
      wsel_r    <= 1'b0;
      rsel_r    <= 1'b0;
      rvalid_r  <= 1'b0;
      zero_r    <= 1'b1;
      frm_cnt_r <= {FRM_CNT_W{1'b0}};
    end else begin
      rvalid_r <= rd_acc_s;
      if (rd_acc_s) begin
        zero_r <= ~raddr_ok_s;
      end
      // Both completions may land together: they touch different banks,
      // because an accepted wr_done needs a free bank and rd_done a full one.
      if (wr_done_acc_s) begin
        full_r[wsel_r] <= 1'b1;
        wsel_r         <= ~wsel_r;
        frm_cnt_r      <= frm_cnt_r + FRM_CNT_W'(1);
      end
      if (rd_done_acc_s) begin
        full_r[rsel_r] <= 1'b0;
        rsel_r         <= ~rsel_r;
      end
    end
  end

  img_bank_ram #(
    .ROW_W (ROW_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr ({wsel_r, waddr}),
    .wdata (wdata),
`ifdef IMG_BUF_WBE_EN
    .wbe   (wbe),
`endif
    .re    (ram_re_s),
    .raddr ({rsel_r, raddr}),
    .rdata (ram_q_s)
  );

endmodule

// File: tb/tb_img_pingpong_buf.sv
// tb_img_pingpong_buf -- scoreboard bench for img_pingpong_buf.
// Driver applies one request set per cycle and pushes the reference
// model's expected outputs; a monitor pops and compares after each edge.
// Small configuration: 32-bit rows, 6 rows per bank (indices 6,7 out of range).
module tb_img_pingpong_buf;

  localparam int RW = 32;
  localparam int D  = 6;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [RW-1:0] wdata = '0;
  logic [3:0]    wbe_v = 4'hF;
`ifdef IMG_BUF_WBE_EN
  logic [3:0]    wbe;
  assign wbe = wbe_v;
`endif
  logic          wr_done = 1'b0;
  logic          wr_rdy;
  logic          re = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          rd_done = 1'b0;
  logic          rd_rdy;
  logic [RW-1:0] rdata;
  logic          rvalid;
  logic [15:0]   frm_cnt;

  always #5 clk = ~clk;

  img_pingpong_buf #(.ROW_W(RW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
`ifdef IMG_BUF_WBE_EN
    .wbe(wbe),
`endif
    .wr_done(wr_done), .wr_rdy(wr_rdy), .re(re), .raddr(raddr),
    .rd_done(rd_done), .rd_rdy(rd_rdy), .rdata(rdata), .rvalid(rvalid),
    .frm_cnt(frm_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        wr;
    logic        rd;
    logic [15:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: frames are a FIFO of filled bank ids.
  logic [31:0] m_mem [2][D];
  int          m_filled[$];
  int          m_wbank = 0;
  logic [15:0] m_cnt = 16'd0;
  logic [31:0] m_last = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per driven cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rvalid", {31'd0, rvalid}, {31'd0, e.v});
        chk("rdata", rdata, e.d);
        chk("wr_rdy", {31'd0, wr_rdy}, {31'd0, e.wr});
        chk("rd_rdy", {31'd0, rd_rdy}, {31'd0, e.rd});
        chk("frm_cnt", {16'd0, frm_cnt}, {16'd0, e.c});
      end
    end
  end

  task automatic step(input logic r, input logic w, input int wa, input logic [31:0] wd,
                      input logic wdn, input logic rr, input int ra, input logic rdn);
    exp_t e;
    bit wr_ok, rd_ok;
    int rb;
    @(negedge clk);
    rst = r; we = w; waddr = AW'(wa); wdata = wd; wr_done = wdn;
    re = rr; raddr = AW'(ra); rd_done = rdn;
    e.v = 1'b0;
    if (r) begin
      m_filled.delete();
      m_wbank = 0;
      m_cnt   = 16'd0;
      m_last  = 32'd0;
    end else begin
      wr_ok = (m_filled.size() < 2);
      rd_ok = (m_filled.size() > 0);
      rb    = rd_ok ? m_filled[0] : 0;
      if (w && wr_ok && wa < D) begin
        for (int b = 0; b < 4; b++)
          if (wbe_v[b]) m_mem[m_wbank][wa][b*8 +: 8] = wd[b*8 +: 8];
      end
      if (rr && rd_ok) begin
        e.v    = 1'b1;
        m_last = (ra < D) ? m_mem[rb][ra] : 32'd0;
      end
      if (rdn && rd_ok) void'(m_filled.pop_front());
      if (wdn && wr_ok) begin
        m_filled.push_back(m_wbank);
        m_wbank ^= 1;
        m_cnt++;
      end
    end
    e.d  = m_last;
    e.wr = (m_filled.size() < 2);
    e.rd = (m_filled.size() > 0);
    e.c  = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, i, base + 32'(i), 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    // Reset, then frame A into bank 0 and read row 2.
    step(1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    fill(32'hA0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 2, 1'b0);
    // Second frame fills both banks; a further write is dropped.
    fill(32'hB0);
    step(1'b0, 1'b1, 0, 32'hFF, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    // Refill bank 0, then wr_done and rd_done together with both full.
    fill(32'hC0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 3, 1'b0);
    // Drain and read while empty; rdata must hold.
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 1, 1'b1);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 4, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 5, 1'b0);
    // Out-of-range write and read.
    step(1'b0, 1'b1, 7, 32'h1234, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 6, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    // Reset mid-frame with a write pending.
    step(1'b0, 1'b1, 1, 32'h55, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 2, 32'h66, 1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
`ifdef IMG_BUF_WBE_EN
    // Byte-enable merge: zero the row, then write ones to byte 0 only.
    step(1'b0, 1'b1, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    wbe_v = 4'h1;
    step(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 1'b0);
    wbe_v = 4'hF;
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 0, 1'b1);
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
`endif
    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom), int'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 5) == 0), 1'($urandom), int'($urandom_range(0, 7)),
           ($urandom_range(0, 5) == 0));
    end
    step(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
